// File: rtl/tetris_move_sched.sv
// tetris_move_sched: input scheduler in front of the tetris core. Turns button edges
//   and a level-dependent gravity timer into one move command at a time (valid/ready),
//   and runs the idle/run/done game FSM. Tracks cleared lines and level.
// Ports: Clk/Reset (async, active-high); Start/Ack/game_over drive the FSM;
//   Left/Right/Down/Rot buttons; move_ready/move_valid/move_code command handshake;
//   lines_valid/lines_cnt line-clear reports; q_I/q_Run/q_Done one-hot state;
//   level and lines_total scores.
// Latency: button rise to move_valid is 2 cycles. Backpressure: move_code holds while
//   move_valid & !move_ready; later requests wait in one pending bit per command.
// Option: define TETRIS_AUTOREPEAT_EN to re-trigger a held Left/Right every REPEAT_DIV cycles.
module tetris_move_sched #(
  parameter int TICK_DIV   = 16,
  parameter int TICK_STEP  = 2,
  parameter int TICK_MIN   = 4,
  parameter int LEVEL_STEP = 4
`ifdef TETRIS_AUTOREPEAT_EN
  , parameter int REPEAT_DIV = 8
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Left,
  input  logic       Right,
  input  logic       Down,
  input  logic       Rot,
  input  logic       move_ready,
  input  logic       game_over,
  input  logic       lines_valid,
  input  logic [2:0] lines_cnt,
  output logic       move_valid,
  output logic [2:0] move_code,
  output logic       q_I,
  output logic       q_Run,
  output logic       q_Done,
  output logic [3:0] level,
  output logic [7:0] lines_total
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(LEVEL_STEP + 5);

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_LEFT  = 3'd1;
  localparam logic [2:0] C_RIGHT = 3'd2;
  localparam logic [2:0] C_DOWN  = 3'd3;
  localparam logic [2:0] C_ROT   = 3'd4;
  localparam logic [2:0] C_GRAV  = 3'd5;

  typedef enum logic [2:0] {QI = 3'b001, QRUN = 3'b010, QDONE = 3'b100} state_t;

  state_t        state_q, state_d;
  logic [3:0]    btn_q, btn_d;      // previous {Rot, Down, Right, Left}
  logic [5:1]    pend_q, pend_d;    // one pending bit per command code
  logic          vld_q, vld_d;
  logic [2:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    level_q, level_d;
  logic [7:0]    total_q, total_d;
  logic [AW-1:0] acc_q, acc_d;
`ifdef TETRIS_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DIV + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  logic [3:0]    rise;
  logic [5:1]    set, clr;
  logic [2:0]    sel, lcnt;
  logic [8:0]    tsum;
  logic [AW-1:0] asum;
  logic [15:0]   red;
  logic [CW-1:0] period;

  // Gravity period shrinks with level down to TICK_MIN; compared before subtracting
  // so a large level cannot wrap the period.
  assign red    = 16'(level_q) * 16'(TICK_STEP);
  assign period = (red + 16'(TICK_MIN) >= 16'(TICK_DIV)) ? CW'(TICK_MIN)
                                                         : CW'(16'(TICK_DIV) - red);

  always_comb begin
    state_d = state_q;
    btn_d   = {Rot, Down, Right, Left};
    pend_d  = pend_q;
    vld_d   = vld_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    total_d = total_q;
    acc_d   = acc_q;
`ifdef TETRIS_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    rise = {Rot, Down, Right, Left} & ~btn_q;
    set  = '0;
    clr  = '0;
    sel  = C_NONE;
    lcnt = (lines_cnt > 3'd4) ? 3'd4 : lines_cnt;
    tsum = 9'(total_q) + 9'(lcnt);
    asum = acc_q + AW'(lcnt);

    case (state_q)
      QI: begin
        if (Start) begin
          state_d = QRUN;
          pend_d  = '0;
          vld_d   = 1'b0;
          code_d  = C_NONE;
          cnt_d   = CW'(TICK_DIV);
          level_d = '0;
          total_d = '0;
          acc_d   = '0;
`ifdef TETRIS_AUTOREPEAT_EN
          rep_d   = RW'(REPEAT_DIV);
`endif
        end
      end
      QRUN: begin
        if (game_over) begin
          state_d = QDONE;
          pend_d  = '0;
          vld_d   = 1'b0;
          code_d  = C_NONE;
        end else begin
          // Simultaneous Left and Right rises cancel each other.
          if (rise[0] & ~rise[1]) set[C_LEFT]  = 1'b1;
          if (rise[1] & ~rise[0]) set[C_RIGHT] = 1'b1;
          if (rise[2])            set[C_DOWN]  = 1'b1;
          if (rise[3])            set[C_ROT]   = 1'b1;
`ifdef TETRIS_AUTOREPEAT_EN
          // Counter runs only while exactly one of Left/Right stays held.
          if ((Left & ~Right & btn_q[0]) | (Right & ~Left & btn_q[1])) begin
            if (rep_q <= RW'(1)) begin
              rep_d = RW'(REPEAT_DIV);
              if (Left) set[C_LEFT]  = 1'b1;
              else      set[C_RIGHT] = 1'b1;
            end else begin
              rep_d = rep_q - RW'(1);
            end
          end else begin
            rep_d = RW'(REPEAT_DIV);
          end
`endif
          // Output slot free or being consumed: load highest-priority pending command.
          if (!vld_q || move_ready) begin
            if      (pend_q[C_ROT])   begin sel = C_ROT;   clr[C_ROT]   = 1'b1; end
            else if (pend_q[C_LEFT])  begin sel = C_LEFT;  clr[C_LEFT]  = 1'b1; end
            else if (pend_q[C_RIGHT]) begin sel = C_RIGHT; clr[C_RIGHT] = 1'b1; end
            else if (pend_q[C_DOWN])  begin sel = C_DOWN;  clr[C_DOWN]  = 1'b1; end
            else if (pend_q[C_GRAV])  begin sel = C_GRAV;  clr[C_GRAV]  = 1'b1; end
            vld_d  = (sel != C_NONE);
            code_d = sel;
          end
          // A soft drop replaces the gravity step and restarts its timer.
          if (sel == C_DOWN) begin
            clr[C_GRAV] = 1'b1;
            cnt_d       = period;
          end else if (cnt_q <= CW'(1)) begin
            set[C_GRAV] = 1'b1;
            cnt_d       = period;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
          // New requests win over a same-cycle issue so no edge is dropped.
          pend_d = (pend_q & ~clr) | set;
          if (lines_valid) begin
            total_d = tsum[8] ? 8'hFF : tsum[7:0];
            if (asum >= AW'(LEVEL_STEP)) begin
              acc_d = asum - AW'(LEVEL_STEP);
              if (level_q != 4'hF) level_d = level_q + 4'd1;
            end else begin
              acc_d = asum;
            end
          end
        end
      end
      QDONE: begin
        if (Ack) state_d = QI;
      end
      default: state_d = QI;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= QI;
      btn_q   <= '0;
      pend_q  <= '0;
      vld_q   <= 1'b0;
      code_q  <= C_NONE;
      cnt_q   <= '0;
      level_q <= '0;
      total_q <= '0;
      acc_q   <= '0;
`ifdef TETRIS_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      total_q <= total_d;
      acc_q   <= acc_d;
`ifdef TETRIS_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign move_valid  = vld_q;
  assign move_code   = code_q;
  assign q_I         = (state_q == QI);
  assign q_Run       = (state_q == QRUN);
  assign q_Done      = (state_q == QDONE);
  assign level       = level_q;
  assign lines_total = total_q;

endmodule

// File: tb/tb_tetris_move_sched.sv
// Bench for tetris_move_sched: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural game model.
module tb_tetris_move_sched;

  logic       Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ack = 1'b0;
  logic       Left = 1'b0, Right = 1'b0, Down = 1'b0, Rot = 1'b0;
  logic       move_ready = 1'b1, game_over = 1'b0, lines_valid = 1'b0;
  logic [2:0] lines_cnt = 3'd0;
  logic       move_valid, q_I, q_Run, q_Done;
  logic [2:0] move_code;
  logic [3:0] level;
  logic [7:0] lines_total;

  always #5 Clk = ~Clk;

  tetris_move_sched dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .Left(Left), .Right(Right), .Down(Down), .Rot(Rot),
    .move_ready(move_ready), .game_over(game_over),
    .lines_valid(lines_valid), .lines_cnt(lines_cnt),
    .move_valid(move_valid), .move_code(move_code),
    .q_I(q_I), .q_Run(q_Run), .q_Done(q_Done),
    .level(level), .lines_total(lines_total)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Game state 0 idle, 1 running, 2 done. Gravity is tracked as the absolute
  // cycle of the next expiry; level is derived from the total of clipped line counts.
  localparam int PRIO[5] = '{4, 1, 2, 3, 5};
  int       m_st = 0, m_code = 0, m_cyc = 0, m_next_grav = 0, m_sum = 0, m_hl = 0, m_hr = 0;
  bit       m_vld = 0, m_pl = 0, m_pr = 0, m_pd = 0, m_pro = 0;
  bit [5:1] m_pend = '0;

  function automatic int m_level();
    int l = m_sum / 4;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic int m_period();
    int p = 16 - 2 * m_level();
    return (p < 4) ? 4 : p;
  endfunction

  always @(posedge Clk or posedge Reset) begin : step
    bit el, er, ed, ero;
    bit [5:1] setm, clrm;
    int sel, per;
    if (Reset) begin
      m_st = 0; m_vld = 0; m_code = 0; m_pend = '0; m_sum = 0;
      m_pl = 0; m_pr = 0; m_pd = 0; m_pro = 0; m_hl = 0; m_hr = 0;
    end else begin
      m_cyc++;
      el = Left && !m_pl; er = Right && !m_pr; ed = Down && !m_pd; ero = Rot && !m_pro;
      if (m_st == 0) begin
        if (Start) begin
          m_st = 1; m_pend = '0; m_vld = 0; m_code = 0; m_sum = 0;
          m_next_grav = m_cyc + 16; m_hl = 0; m_hr = 0;
        end
      end else if (m_st == 1) begin
        if (game_over) begin
          m_st = 2; m_pend = '0; m_vld = 0; m_code = 0;
        end else begin
          per = m_period();
          setm = '0; clrm = '0; sel = 0;
          if (el && !er) setm[1] = 1;
          if (er && !el) setm[2] = 1;
          if (ed)  setm[3] = 1;
          if (ero) setm[4] = 1;
`ifdef TETRIS_AUTOREPEAT_EN
          if (Left && !Right && m_pl) begin m_hl++; if (m_hl % 8 == 0) setm[1] = 1; end
          else m_hl = 0;
          if (Right && !Left && m_pr) begin m_hr++; if (m_hr % 8 == 0) setm[2] = 1; end
          else m_hr = 0;
`endif
          if (!m_vld || move_ready) begin
            for (int i = 0; i < 5; i++) if (sel == 0 && m_pend[PRIO[i]]) sel = PRIO[i];
            m_vld = (sel != 0);
            m_code = sel;
            if (sel != 0) clrm[sel] = 1;
          end
          if (sel == 3) begin
            clrm[5] = 1; m_next_grav = m_cyc + per;
          end else if (m_cyc == m_next_grav) begin
            setm[5] = 1; m_next_grav = m_cyc + per;
          end
          if (lines_valid) m_sum += (lines_cnt > 4) ? 4 : int'(lines_cnt);
          m_pend = (m_pend & ~clrm) | setm;
        end
      end else begin
        if (Ack) m_st = 0;
      end
      m_pl = Left; m_pr = Right; m_pd = Down; m_pro = Rot;
    end
  end

  // ---------------- compare / monitor ----------------
  bit cmp_en = 0;
  int ncyc = 0, grav_seen = 0, grav_t = 0, left_seen = 0, right_seen = 0;

  always @(negedge Clk) begin
    ncyc++;
    if (cmp_en) begin
      chk("move_valid", int'(move_valid), int'(m_vld));
      chk("move_code", int'(move_code), m_code);
      chk("state", int'({q_I, q_Run, q_Done}), (m_st == 0) ? 4 : (m_st == 1) ? 2 : 1);
      chk("level", int'(level), m_level());
      chk("lines_total", int'(lines_total), (m_sum > 255) ? 255 : m_sum);
    end
    if (move_valid && move_ready) begin
      if (move_code == 3'd5) begin grav_seen++; grav_t = ncyc; end
      if (move_code == 3'd1) left_seen++;
      if (move_code == 3'd2) right_seen++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grav();
    int n0 = grav_seen;
    int k = 0;
    while (grav_seen == n0 && k < 100) begin tick(); k++; end
    if (grav_seen == n0) chk("grav_timeout", 0, 1);
  endtask

  task automatic meas_gap(output int gap);
    int t1;
    wait_grav();
    wait_grav();
    t1 = grav_t;
    wait_grav();
    gap = grav_t - t1;
  endtask

  task automatic pulse_lines(input int cnt);
    lines_valid = 1'b1; lines_cnt = 3'(cnt);
    tick();
    lines_valid = 1'b0;
    tick();
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s0, n;
    ticks(3);
    cmp_en = 1;
    chk("rst_q_I", int'(q_I), 1);
    chk("rst_q_Run", int'(q_Run), 0);
    chk("rst_q_Done", int'(q_Done), 0);
    chk("rst_valid", int'(move_valid), 0);
    chk("rst_code", int'(move_code), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_total", int'(lines_total), 0);
    Reset = 1'b0;
    tick();

    // Start and idle gravity
    do_start();
    chk("start_q_Run", int'(q_Run), 1);
    chk("start_q_I", int'(q_I), 0);
    meas_gap(g);
    chk("gap_lvl0", g, 16);

    // Single Left edge, held
    wait_grav();
    s0 = left_seen;
    Left = 1'b1;
    tick();
    chk("left_lat1_valid", int'(move_valid), 0);
    tick();
    chk("left_valid", int'(move_valid), 1);
    chk("left_code", int'(move_code), 1);
    tick();
    chk("left_single", int'(move_valid), 0);
    ticks(20);
    Left = 1'b0;
    ticks(2);
`ifdef TETRIS_AUTOREPEAT_EN
    chk("left_count", left_seen - s0, 3);
`else
    chk("left_count", left_seen - s0, 1);
`endif

    // Rot then Left under backpressure
    wait_grav();
    move_ready = 1'b0;
    Rot = 1'b1;
    tick();
    Left = 1'b1;
    ticks(2);
    chk("stall_valid", int'(move_valid), 1);
    chk("stall_code", int'(move_code), 4);
    ticks(5);
    chk("stall_hold_code", int'(move_code), 4);
    move_ready = 1'b1;
    tick();
    chk("after_stall_code", int'(move_code), 1);
    chk("after_stall_valid", int'(move_valid), 1);
    Rot = 1'b0; Left = 1'b0;
    ticks(2);

    // Left and Right rise together
    s0 = left_seen + right_seen;
    Left = 1'b1; Right = 1'b1;
    ticks(12);
    Left = 1'b0; Right = 1'b0;
    ticks(3);
    chk("lr_cancel", left_seen + right_seen - s0, 0);

    // Down exactly at gravity expiry
    wait_grav();
    ticks(13);
    Down = 1'b1;
    ticks(2);
    chk("down_code", int'(move_code), 3);
    chk("down_valid", int'(move_valid), 1);
    n = ncyc;
    tick();
    Down = 1'b0;
    wait_grav();
    chk("down_grav_delay", grav_t - n, 18);

    // Lines and level
    pulse_lines(4);
    pulse_lines(4);
    chk("lines8_total", int'(lines_total), 8);
    chk("lines8_level", int'(level), 2);
    meas_gap(g);
    chk("gap_lvl2", g, 12);
    for (int i = 0; i < 13; i++) pulse_lines(4);
    chk("lines60_total", int'(lines_total), 60);
    chk("lines60_level", int'(level), 15);
    meas_gap(g);
    chk("gap_lvl15", g, 4);
    pulse_lines(7);
    chk("clip_total", int'(lines_total), 64);

    // game_over with a pending Rot
    wait_grav();
    move_ready = 1'b0;
    Left = 1'b1;
    ticks(2);
    Rot = 1'b1;
    tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0; Rot = 1'b0; Left = 1'b0; move_ready = 1'b1;
    chk("go_q_Done", int'(q_Done), 1);
    chk("go_valid", int'(move_valid), 0);
    tick();
    chk("done_valid", int'(move_valid), 0);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk("ack_q_I", int'(q_I), 1);
    Left = 1'b1;
    ticks(3);
    chk("idle_no_cmd", int'(move_valid), 0);
    Left = 1'b0;
    tick();

    // Reset in the middle of a move
    do_start();
    wait_grav();
    Left = 1'b1;
    ticks(2);
    chk("pre_rst_valid", int'(move_valid), 1);
    #1 Reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(move_valid), 0);
    chk("mid_rst_code", int'(move_code), 0);
    chk("mid_rst_q_I", int'(q_I), 1);
    chk("mid_rst_q_Run", int'(q_Run), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_total", int'(lines_total), 0);
    Left = 1'b0;
    ticks(2);
    Reset = 1'b0;
    tick();

    // Randomized phase
    do_start();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) Left  = ~Left;
      if ($urandom_range(0, 5) == 0) Right = ~Right;
      if ($urandom_range(0, 6) == 0) Down  = ~Down;
      if ($urandom_range(0, 6) == 0) Rot   = ~Rot;
      move_ready  = ($urandom_range(0, 3) != 0);
      lines_valid = ($urandom_range(0, 9) == 0);
      lines_cnt   = 3'($urandom_range(0, 7));
      game_over   = ($urandom_range(0, 119) == 0);
      Start       = ($urandom_range(0, 7) == 0);
      Ack         = ($urandom_range(0, 9) == 0);
      tick();
    end
    Left = 1'b0; Right = 1'b0; Down = 1'b0; Rot = 1'b0;
    lines_valid = 1'b0; game_over = 1'b0; Start = 1'b0; Ack = 1'b0; move_ready = 1'b1;
    ticks(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
